// File: rtl/portin_stream.sv
// portin_stream: serial ingress port that turns frame_n/valid_n/di into addressed payload
// words behind a first-word-fall-through FIFO. Defining PORTIN_PARITY_EN makes the final bit an even-parity trailer.
module portin_stream #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              di,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_perr,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_len
);
  localparam int CA_W = $clog2(ADDR_W + 1);
  localparam int CB_W = $clog2(DATA_W);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int PW   = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CA_W-1:0]   cnta;
  logic [DATA_W-1:0] shreg, shreg_nxt, word_next, push_data;
  logic [CB_W-1:0]   cntb, cntb_nxt;
  logic [WC_W-1:0]   wcnt;
  logic              take, fin, addr_wr, push_req, push_ok, len_hit, reset_frame;
  logic              pop, full;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DEPTH-1:0]  mem_last;
`ifdef PORTIN_PARITY_EN
  logic              par, held, held_nxt, push_perr;
  logic [DEPTH-1:0]  mem_perr;
`endif

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == (PW+1)'(DEPTH));
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_last  = out_valid && mem_last[rd_ptr];
`ifdef PORTIN_PARITY_EN
  assign out_perr  = out_valid && mem_perr[rd_ptr];
`else
  assign out_perr  = 1'b0;
`endif
  assign busy      = (state != IDLE);

  always_comb begin
    word_next = shreg;
    for (int i = 0; i < DATA_W; i++)
      if (cntb == CB_W'(i)) word_next[i] = di;
    take    = !valid_n && ((state == IDLE && !frame_n) || state == ADDR || state == DATA);
    fin     = take && frame_n;
    addr_wr = !frame_n && valid_n && (state == IDLE || state == ADDR);
`ifdef PORTIN_PARITY_EN
    // A completed word waits in shreg until the next bit shows whether it was the frame's last.
    push_req  = take && (fin || held);
    push_data = shreg;
    push_perr = fin && (par ^ di);
    if (held) begin
      shreg_nxt = {{(DATA_W-1){1'b0}}, di};
      cntb_nxt  = CB_W'(1);
      held_nxt  = 1'b0;
    end else if (cntb == CB_W'(DATA_W-1)) begin
      shreg_nxt = word_next;
      cntb_nxt  = '0;
      held_nxt  = 1'b1;
    end else begin
      shreg_nxt = word_next;
      cntb_nxt  = cntb + CB_W'(1);
      held_nxt  = 1'b0;
    end
`else
    push_req  = take && (fin || cntb == CB_W'(DATA_W-1));
    push_data = word_next;
    shreg_nxt = push_req ? '0 : word_next;
    cntb_nxt  = push_req ? '0 : cntb + CB_W'(1);
`endif
    len_hit     = (wcnt == WC_W'(MAX_WORDS));
    push_ok     = push_req && !len_hit && (!full || pop);
    reset_frame = (state != IDLE && frame_n && valid_n) || fin || (push_req && !push_ok);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      cnta    <= '0;
      shreg   <= '0;
      cntb    <= '0;
      wcnt    <= '0;
      err_ovf <= 1'b0;
      err_len <= 1'b0;
`ifdef PORTIN_PARITY_EN
      par     <= 1'b0;
      held    <= 1'b0;
`endif
    end else if (clear) begin
      state   <= IDLE;
      addr    <= '0;
      cnta    <= '0;
      shreg   <= '0;
      cntb    <= '0;
      wcnt    <= '0;
      err_ovf <= 1'b0;
      err_len <= 1'b0;
`ifdef PORTIN_PARITY_EN
      par     <= 1'b0;
      held    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:       if (!frame_n) state <= valid_n ? ADDR : DATA;
        ADDR, DATA: if (frame_n && valid_n) state <= IDLE;
                    else if (!valid_n) state <= DATA;
        DROP:       if (frame_n && valid_n) state <= IDLE;
        default:    state <= IDLE;
      endcase
      if (addr_wr) begin
        for (int i = 0; i < ADDR_W; i++)
          if (cnta == CA_W'(i)) addr[i] <= di;
        if (cnta != CA_W'(ADDR_W)) cnta <= cnta + CA_W'(1);
      end
      if (take) begin
        shreg <= shreg_nxt;
        cntb  <= cntb_nxt;
`ifdef PORTIN_PARITY_EN
        par   <= par ^ di;
        held  <= held_nxt;
`endif
      end
      if (push_ok) wcnt <= wcnt + WC_W'(1);
      if (fin) state <= IDLE;
      if (push_req && !push_ok) begin
        state <= DROP;
        if (len_hit) err_len <= 1'b1;
        else         err_ovf <= 1'b1;
      end
      // Leaving a frame (done, aborted or dropped) leaves the assembly registers ready for the next one.
      if (reset_frame) begin
        addr  <= '0;
        cnta  <= '0;
        shreg <= '0;
        cntb  <= '0;
        wcnt  <= '0;
`ifdef PORTIN_PARITY_EN
        par   <= 1'b0;
        held  <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) begin
      mem_data[wr_ptr] <= push_data;
      mem_addr[wr_ptr] <= addr;
      mem_last[wr_ptr] <= fin;
`ifdef PORTIN_PARITY_EN
      mem_perr[wr_ptr] <= push_perr;
`endif
    end
  end

endmodule

// File: tb/tb_portin_stream.sv
// tb_portin_stream: directed self-checking bench for portin_stream (default parameters).
// Parity checks are compiled in when PORTIN_PARITY_EN is defined.
module tb_portin_stream;
  logic        clock, reset, frame_n, valid_n, di, clear, out_ready;
  logic        out_valid, out_last, out_perr, busy, err_ovf, err_len;
  logic [3:0]  out_addr;
  logic [31:0] out_data;

  int checks, errors;
  logic [31:0] tx_words [$];
  logic [31:0] cap_data [$];
  logic [3:0]  cap_addr [$];
  logic        cap_last [$];

  portin_stream dut (
    .clock(clock), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .di(di),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .out_perr(out_perr), .busy(busy),
    .err_ovf(err_ovf), .err_len(err_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records every word handed to the consumer; inputs change only at posedge+2.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_addr.push_back(out_addr);
      cap_last.push_back(out_last);
    end
  end

  task automatic applyStimulus(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    di      = d;
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends nab address bits then nbits payload bits from tx_words, LSB first.
  task automatic send_frame(input logic [7:0] abits, input int nab, input int nbits, input int pbit);
    logic        par;
    logic        b;
    logic [31:0] w;
    par = 1'b0;
    for (int i = 0; i < nab; i++) applyStimulus(1'b0, 1'b1, abits[i]);
    for (int k = 0; k < nbits; k++) begin
      w = tx_words[k/32];
      b = w[k%32];
      par ^= b;
`ifdef PORTIN_PARITY_EN
      applyStimulus(1'b0, 1'b0, b);
`else
      applyStimulus(k == nbits-1, 1'b0, b);
`endif
    end
`ifdef PORTIN_PARITY_EN
    applyStimulus(1'b1, 1'b0, (pbit < 0) ? par : pbit[0]);
`else
    if (pbit > 1) $display("[TB] parity bit %0d ignored", pbit);
`endif
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_addr.delete();
    cap_last.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; clear = 1'b0; frame_n = 1'b1; valid_n = 1'b1; di = 1'b0; out_ready = 1'b0;
    #2;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_addr", out_addr, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_perr", out_perr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", err_ovf, 0);
    checkOutput("rst_len", err_len, 0);
    @(posedge clock); #2;
    reset = 1'b0;

    $display("[TB] single word 0xDEADBEEF");
    out_ready = 1'b1;
    tx_words = '{32'hDEADBEEF};
    send_frame(8'h05, 4, 32, -1);
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_addr", out_addr, 4'h5);
    checkOutput("t1_data", out_data, 32'hDEADBEEF);
    checkOutput("t1_last", out_last, 1);
    checkOutput("t1_busy", busy, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t1_valid_drop", out_valid, 0);
    checkOutput("t1_npop", cap_data.size(), 1);

    $display("[TB] three words under back-pressure");
    clear_caps();
    out_ready = 1'b0;
    tx_words = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_frame(8'h03, 4, 96, -1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t2_head", out_data, 32'h11111111);
    checkOutput("t2_head_last", out_last, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t2_head_stable", out_data, 32'h11111111);
    checkOutput("t2_addr", out_addr, 4'h3);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t2_npop", cap_data.size(), 3);
    checkOutput("t2_w0", cap_data[0], 32'h11111111);
    checkOutput("t2_w1", cap_data[1], 32'h22222222);
    checkOutput("t2_w2", cap_data[2], 32'h33333333);
    checkOutput("t2_lasts", {cap_last[0], cap_last[1], cap_last[2]}, 3'b001);
    checkOutput("t2_empty", out_valid, 0);

    $display("[TB] overflow then clear");
    clear_caps();
    out_ready = 1'b0;
    tx_words = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
    send_frame(8'h02, 4, 160, -1);
    checkOutput("t3_ovf", err_ovf, 1);
    checkOutput("t3_drop_busy", busy, 1);
    checkOutput("t3_head", out_data, 32'hA0000001);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t3_idle", busy, 0);
    clear = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    checkOutput("t3_ovf_clr", err_ovf, 0);
    checkOutput("t3_fifo_clr", out_valid, 0);
    out_ready = 1'b1;
    tx_words = '{32'hCAFEF00D};
    send_frame(8'h09, 4, 32, -1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t3_npop", cap_data.size(), 1);
    checkOutput("t3_data", cap_data[0], 32'hCAFEF00D);
    checkOutput("t3_addr", cap_addr[0], 4'h9);
    checkOutput("t3_last", cap_last[0], 1);

    $display("[TB] nine-word frame exceeds length limit");
    clear_caps();
    tx_words.delete();
    for (int i = 0; i < 9; i++) tx_words.push_back(32'h10000000 + 32'(i));
    send_frame(8'h0A, 4, 288, -1);
    checkOutput("t4_len", err_len, 1);
    checkOutput("t4_ovf", err_ovf, 0);
    checkOutput("t4_drop_busy", busy, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_idle", busy, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_npop", cap_data.size(), 8);
    checkOutput("t4_w7", cap_data[7], 32'h10000007);
    checkOutput("t4_addr", cap_addr[0], 4'hA);
    checkOutput("t4_nolast", cap_last[0] | cap_last[3] | cap_last[7], 0);

    $display("[TB] abort, then 12-bit frame with no address");
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_busy_mid", busy, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_abort_idle", busy, 0);
    checkOutput("t5_abort_nopush", out_valid, 0);
    clear_caps();
    tx_words = '{32'h00000ABC};
    send_frame(8'h00, 0, 12, -1);
    checkOutput("t5_valid", out_valid, 1);
    checkOutput("t5_data", out_data, 32'h00000ABC);
    checkOutput("t5_addr", out_addr, 0);
    checkOutput("t5_last", out_last, 1);
    checkOutput("t5_perr", out_perr, 0);
    checkOutput("t5_len_sticky", err_len, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-frame");
    out_ready = 1'b0;
    tx_words = '{32'h12345678};
    send_frame(8'h06, 4, 32, -1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_pre_valid", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_valid", out_valid, 0);
    checkOutput("t6_data", out_data, 0);
    checkOutput("t6_addr", out_addr, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_len", err_len, 0);
    frame_n = 1'b1; valid_n = 1'b1; di = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    clear_caps();
    out_ready = 1'b1;
    tx_words = '{32'h0F0F0F0F};
    send_frame(8'h01, 4, 32, -1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t6_npop", cap_data.size(), 1);
    checkOutput("t6_first", cap_data[0], 32'h0F0F0F0F);
    checkOutput("t6_first_addr", cap_addr[0], 4'h1);

`ifdef PORTIN_PARITY_EN
    $display("[TB] parity trailer");
    tx_words = '{32'h00000001};
    send_frame(8'h00, 0, 32, 0);
    checkOutput("t7_perr_bad", out_perr, 1);
    checkOutput("t7_data", out_data, 32'h00000001);
    applyStimulus(1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 0, 32, 1);
    checkOutput("t7_perr_good", out_perr, 0);
    checkOutput("t7_last", out_last, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/portin_stream.md
# portin_stream

Parametrised serial ingress port for the router. It deserialises one serial input lane (frame_n / valid_n / di) into an ADDR_W-bit destination address and a stream of DATA_W-bit payload words. The words are buffered in a DEPTH-entry first-word-fall-through FIFO and presented to the switch fabric over a valid/ready handshake. This is the multi-word, back-pressured successor to the single-word input port: it adds frame length checking, sticky error flags and optional parity.

## Interface
- ADDR_W, 4, address bits per frame (1..8)
- DATA_W, 32, bits per payload word (8..64)
- DEPTH, 4, FIFO entries, power of two, at least 2
- MAX_WORDS, 8, maximum payload words per frame (at least 1)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- frame_n  in  1  frame active when low
- valid_n  in  1  payload bit valid when low
- di  in  1  serial data, LSB first
- clear  in  1  synchronous flush: FIFO, counters, FSM and sticky errors
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_addr  out  ADDR_W  frame address of head word
- out_data  out  DATA_W  head payload word
- out_last  out  1  head is the final word of its frame
- out_perr  out  1  parity error on the frame's last word (PORTIN_PARITY_EN only)
- busy  out  1  FSM not in IDLE
- err_ovf  out  1  sticky: a word was dropped because the FIFO was full
- err_len  out  1  sticky: a frame exceeded MAX_WORDS

## Operation
- States: IDLE, ADDR, DATA, DROP.
- IDLE → ADDR on frame_n=0 and valid_n=1. IDLE → DATA directly on frame_n=0 and valid_n=0; the address is then all zero.
- ADDR: each cycle with frame_n=0 and valid_n=1 writes di into addr[cnta], LSB first. Bits beyond ADDR_W are ignored. Unreceived address bits are 0.
- ADDR → DATA on the first cycle with valid_n=0. That cycle's di is payload bit 0.
- DATA: each cycle with valid_n=0 shifts di into word bit cntb. A cycle with valid_n=1 inside the frame is a stall: no bit is taken and the state is held.
- When cntb reaches DATA_W-1 the full word is pushed with out_last=0.
- Frame end: a cycle with frame_n=1 and valid_n=0 takes the final bit. The current word is pushed with out_last=1; unfilled upper bits are 0. If that bit completes an exactly full word, that word carries out_last=1.
- frame_n=1 with valid_n=1 while in ADDR or DATA: the frame is aborted. Nothing is pushed and the state returns to IDLE.
- Overflow: a push while the FIFO is full and no pop occurs in the same cycle drops the word, sets err_ovf and enters DROP.
- Length: a push that would be word MAX_WORDS+1 of a frame is discarded, sets err_len and enters DROP.
- DROP → IDLE on the first cycle with frame_n=1 and valid_n=1.
- A pop occurs when out_valid=1 and out_ready=1. A push and a pop may happen in the same cycle, including when the FIFO is full.
- Address width rule: the address counter saturates at ADDR_W, so it never wraps.
- clear=1 has priority over all other activity. It empties the FIFO, zeroes the counters and shift register, selects IDLE, and clears err_ovf and err_len. A frame in flight when clear is asserted is lost.

## Timing
- Reset values: out_valid=0, out_addr=0, out_data=0, out_last=0, out_perr=0, busy=0, err_ovf=0, err_len=0. FSM=IDLE and FIFO empty.
- Reset asserted mid-frame discards all state immediately, without waiting for a clock edge.
- Latency: the edge that samples a word's final bit writes the FIFO, and out_valid=1 in the following cycle. This is 1 cycle.
- out_addr, out_data and out_last are stable while out_valid=1 and out_ready=0.
- Maximum throughput is one bit per clock in and one word per clock out.

## Configuration
- PORTIN_PARITY_EN defined:
  - The frame's final bit (frame_n=1, valid_n=0) is an even-parity bit and is not payload.
  - The last word is pushed from the bits already held.
  - out_perr=1 on that word when the XOR of all payload bits differs from the parity bit.
- PORTIN_PARITY_EN undefined:
  - The final bit is payload, as described in Operation.
  - out_perr is tied to 0.

## Test plan
- Reset, then addr bits 1,0,1,0 followed by 32 payload bits forming 0xDEADBEEF with out_ready=1 → one word: out_addr=0x5, out_data=0xDEADBEEF, out_last=1, out_valid high for 1 cycle.
- Three-word frame with out_ready=0 throughout, DEPTH=4 → 3 entries held. Then out_ready=1 → words pop in order, with out_last=1 only on the third.
- Five-word frame with DEPTH=4 and out_ready=0 → err_ovf=1 and the fifth word is dropped. Next frame after clear → err_ovf=0 and the frame is delivered intact.
- Frame of 9 words with MAX_WORDS=8 and out_ready=1 → 8 words delivered with no out_last, err_len=1, FSM in DROP until idle.
- Frame of 12 payload bits 0xABC → out_data=0x00000ABC, out_last=1. Reset mid-frame → all outputs at reset values and the FIFO empty.
- PORTIN_PARITY_EN defined, payload 0x00000001 with parity bit 0 → out_perr=1; the same payload with parity bit 1 → out_perr=0.
